// File: rtl/coin_pkg.sv
// Shared coin codes, channel state encoding and default timing for the coin acceptor.
package coin_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam int DB_CYCLES_DFLT  = 4;
  localparam int JAM_CYCLES_DFLT = 64;
  localparam int CNT_W_DFLT      = 7;

  typedef enum logic [2:0] {
    IDLE,
    DEB_HI,
    HELD,
    DEB_LO,
    JAM
  } chan_state_t;
endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle: raw sensors in, coin codes and jam status out.
// COIN_TALLY_EN adds the tally output.
interface coin_acceptor_if;
  import coin_pkg::*;

  // Handshake: coin_out is a one-cycle strobe with no ready; the consumer must take
  // every non-zero code in the cycle it appears, and at most one code is shown per cycle.
  logic        sense_5;
  logic        sense_10;
  logic [1:0]  coin_out;
  logic        reject;
  logic        jam;
  chan_state_t state_5;
  chan_state_t state_10;
`ifdef COIN_TALLY_EN
  logic [15:0] tally;

  modport master (input sense_5, sense_10,
                  output coin_out, reject, jam, state_5, state_10, tally);
  modport slave  (output sense_5, sense_10,
                  input coin_out, reject, jam, state_5, state_10, tally);
`else
  modport master (input sense_5, sense_10,
                  output coin_out, reject, jam, state_5, state_10);
  modport slave  (output sense_5, sense_10,
                  input coin_out, reject, jam, state_5, state_10);
`endif
endinterface

// File: rtl/coin_chan.sv
// One coin slot: 2-flop synchroniser, debounce/jam FSM and sample counter.
// Produces a credit strobe on coin release and a jam_enter strobe on jam detection.
module coin_chan
  import coin_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DFLT,
  parameter int JAM_CYCLES = JAM_CYCLES_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sense,
  output logic        credit,
  output logic        jam_enter,
  output logic        in_jam,
  output chan_state_t state
);
  localparam logic [CNT_W-1:0] DB_L  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] JAM_L = CNT_W'(JAM_CYCLES);

  logic             s1, s2;
  logic [1:0]       vld;
  logic             armed;
  chan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

  // A coin already in the slot across reset is discarded: the channel only arms
  // once a genuine (post-synchroniser-fill) low sample has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      vld   <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1  <= sense;
      s2  <= s1;
      vld <= {vld[0], 1'b1};
      if (vld[1] && !s2) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (s2 && armed) begin
          state_nxt = DEB_HI;
          cnt_nxt   = CNT_W'(1);
        end
      end
      DEB_HI: begin
        if (!s2)                 begin state_nxt = IDLE; cnt_nxt = '0; end
        else if (cnt_inc == DB_L) begin state_nxt = HELD; cnt_nxt = '0; end
        else                     cnt_nxt = cnt_inc;
      end
      HELD: begin
        if (!s2)                   begin state_nxt = DEB_LO; cnt_nxt = CNT_W'(1); end
        else if (cnt_inc == JAM_L) begin state_nxt = JAM;    cnt_nxt = '0; end
        else                       cnt_nxt = cnt_inc;
      end
      DEB_LO: begin
        if (s2)                   begin state_nxt = HELD; cnt_nxt = '0; end
        else if (cnt_inc == DB_L) begin state_nxt = IDLE; cnt_nxt = '0; end
        else                      cnt_nxt = cnt_inc;
      end
      JAM: begin
        if (s2)                   cnt_nxt = '0;
        else if (cnt_inc == DB_L) begin state_nxt = IDLE; cnt_nxt = '0; end
        else                      cnt_nxt = cnt_inc;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    credit    = (state == DEB_LO) && !s2 && (cnt_inc == DB_L);
    jam_enter = (state == HELD) && s2 && (cnt_inc == JAM_L);
    in_jam    = (state == JAM);
  end
endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: two debounced channels, one-code-per-cycle arbitration, registered outputs.
// Build with COIN_TALLY_EN to add a saturating credited-value tally.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DFLT,
  parameter int JAM_CYCLES = JAM_CYCLES_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input logic             clk,
  input logic             rst,
  coin_acceptor_if.master bus
);
  logic        credit_5, credit_10;
  logic        jam_enter_5, jam_enter_10;
  logic        in_jam_5, in_jam_10;
  chan_state_t st_5, st_10;
  logic        pend_5, pend_10;
  logic        serve_5, serve_10;
  logic [1:0]  coin_q;
  logic        reject_q, jam_q;

  coin_chan #(.DB_CYCLES(DB_CYCLES), .JAM_CYCLES(JAM_CYCLES), .CNT_W(CNT_W)) u_chan_5 (
    .clk(clk), .rst(rst), .sense(bus.sense_5),
    .credit(credit_5), .jam_enter(jam_enter_5), .in_jam(in_jam_5), .state(st_5)
  );

  coin_chan #(.DB_CYCLES(DB_CYCLES), .JAM_CYCLES(JAM_CYCLES), .CNT_W(CNT_W)) u_chan_10 (
    .clk(clk), .rst(rst), .sense(bus.sense_10),
    .credit(credit_10), .jam_enter(jam_enter_10), .in_jam(in_jam_10), .state(st_10)
  );

  // The 5-unit channel wins ties; a waiting 10-unit credit goes out the next cycle.
  assign serve_5  = pend_5;
  assign serve_10 = pend_10 && !pend_5;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_5   <= 1'b0;
      pend_10  <= 1'b0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      pend_5   <= credit_5  || (pend_5  && !serve_5);
      pend_10  <= credit_10 || (pend_10 && !serve_10);
      coin_q   <= serve_5 ? COIN_5 : (serve_10 ? COIN_10 : COIN_NONE);
      reject_q <= jam_enter_5 || jam_enter_10;
      jam_q    <= in_jam_5 || in_jam_10;
    end
  end

  assign bus.coin_out = coin_q;
  assign bus.reject   = reject_q;
  assign bus.jam      = jam_q;
  assign bus.state_5  = st_5;
  assign bus.state_10 = st_10;

`ifdef COIN_TALLY_EN
  logic [15:0] tally_q;
  logic [16:0] tally_sum;

  assign tally_sum = {1'b0, tally_q} + 17'((coin_q == COIN_5) ? 2'd1 :
                                          (coin_q == COIN_10) ? 2'd2 : 2'd0);

  always_ff @(posedge clk) begin
    if (rst)             tally_q <= '0;
    else if (tally_sum[16]) tally_q <= 16'hFFFF;
    else                 tally_q <= tally_sum[15:0];
  end

  assign bus.tally = tally_q;
`endif
endmodule
